pipe_front_regs: RTL and testbench

Pipeline-register bank for the fetch, decode and execute front end of the 5-stage RISC-V core. It holds the PC register, the IF/ID register and the ID/EX register, and applies the stall and flush commands produced by the hazard unit. Each register is loaded, held or cleared according to those commands. The block also keeps two saturating performance counters for stall and flush cycles. It sits between the fetch/decode datapath and the execute stage, and its E-stage outputs (Rs1E, Rs2E, RdE, ctrlE) feed back to the hazard unit.

---
 rtl/pipe_front_regs.sv | 213 +++++++++++++++++++++
 tb/tb_pipe_front_regs.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_front_regs.sv
// pipe_front_regs
//   Pipeline-register bank for the fetch/decode/execute front end of the
//   5-stage RISC-V core. It holds the PC register, the IF/ID register and the
//   ID/EX register. It applies the stall and flush commands from the hazard
//   unit, and it keeps saturating stall and flush cycle counters.
//
// Ports
//   clk, rst                        clock (rising edge), synchronous active-high reset
//   stallF, stallD                  hold the PC register / the IF/ID register
//   flushD, flushE                  bubble the IF/ID / ID/EX register
//   PCNextF, instrF, PCPlus4F       fetch-stage inputs
//   RD1D, RD2D, immExtD             decode-stage operands
//   Rs1D, Rs2D, RdD, ctrlD          decode-stage register indices and control bundle
//   PCF                             current fetch PC
//   instrD, PCD, PCPlus4D, validD   IF/ID contents
//   RD1E, RD2E, immExtE, PCE,
//   PCPlus4E, Rs1E, Rs2E, RdE,
//   ctrlE, validE                   ID/EX contents
//   stallCycles, flushCycles        saturating performance counters
module pipe_front_regs #(
  parameter int                 XLEN     = 32,
  parameter int                 CTRL_W   = 16,
  parameter logic [XLEN-1:0]    RESET_PC = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              flushD,
  input  logic              flushE,
  input  logic [XLEN-1:0]   PCNextF,
  input  logic [XLEN-1:0]   instrF,
  input  logic [XLEN-1:0]   PCPlus4F,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   immExtD,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        RdD,
  input  logic [CTRL_W-1:0] ctrlD,
  output logic [XLEN-1:0]   PCF,
  output logic [XLEN-1:0]   instrD,
  output logic [XLEN-1:0]   PCD,
  output logic [XLEN-1:0]   PCPlus4D,
  output logic              validD,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   immExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic [CTRL_W-1:0] ctrlE,
  output logic              validE,
  output logic [CNT_W-1:0]  stallCycles,
  output logic [CNT_W-1:0]  flushCycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // PC register
  logic [XLEN-1:0] pc_q, pc_d;

  // IF/ID register
  logic [XLEN-1:0] instr_d_q, instr_d_d;
  logic [XLEN-1:0] pc_d_q, pc_d_d;
  logic [XLEN-1:0] pc_plus4_d_q, pc_plus4_d_d;
  logic            valid_d_q, valid_d_d;

  // ID/EX register
  logic [XLEN-1:0]   rd1_e_q, rd1_e_d;
  logic [XLEN-1:0]   rd2_e_q, rd2_e_d;
  logic [XLEN-1:0]   imm_ext_e_q, imm_ext_e_d;
  logic [XLEN-1:0]   pc_e_q, pc_e_d;
  logic [XLEN-1:0]   pc_plus4_e_q, pc_plus4_e_d;
  logic [4:0]        rs1_e_q, rs1_e_d;
  logic [4:0]        rs2_e_q, rs2_e_d;
  logic [4:0]        rd_e_q, rd_e_d;
  logic [CTRL_W-1:0] ctrl_e_q, ctrl_e_d;
  logic              valid_e_q, valid_e_d;

  // Performance counters
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_inc, flush_inc;

  always_comb begin
    pc_d = stallF ? pc_q : PCNextF;
  end

  // The flush check comes first, so a flush beats a simultaneous stall and
  // the bubble it inserts is never kept alive by the stall.
  always_comb begin
    instr_d_d    = instrF;
    pc_d_d       = pc_q;
    pc_plus4_d_d = PCPlus4F;
    valid_d_d    = 1'b1;
    if (flushD) begin
      instr_d_d    = '0;
      pc_d_d       = '0;
      pc_plus4_d_d = '0;
      valid_d_d    = 1'b0;
    end else if (stallD) begin
      instr_d_d    = instr_d_q;
      pc_d_d       = pc_d_q;
      pc_plus4_d_d = pc_plus4_d_q;
      valid_d_d    = valid_d_q;
    end
  end

  // ID/EX has no hold path. A load-use stall bubbles E through flushE. The
  // all-zero bubble (ctrlE=0, RdE=0) writes nothing and forwards nothing.
  always_comb begin
    rd1_e_d      = RD1D;
    rd2_e_d      = RD2D;
    imm_ext_e_d  = immExtD;
    pc_e_d       = pc_d_q;
    pc_plus4_e_d = pc_plus4_d_q;
    rs1_e_d      = Rs1D;
    rs2_e_d      = Rs2D;
    rd_e_d       = RdD;
    ctrl_e_d     = ctrlD;
    valid_e_d    = valid_d_q;
    if (flushE) begin
      rd1_e_d      = '0;
      rd2_e_d      = '0;
      imm_ext_e_d  = '0;
      pc_e_d       = '0;
      pc_plus4_e_d = '0;
      rs1_e_d      = '0;
      rs2_e_d      = '0;
      rd_e_d       = '0;
      ctrl_e_d     = '0;
      valid_e_d    = 1'b0;
    end
  end

  // A stall that is overridden by flushD is not counted as a stall. A flushD
  // counts as a flush only when it discards a real instruction.
  always_comb begin
    stall_inc   = stallD & ~flushD;
    flush_inc   = flushE | (flushD & valid_d_q);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      instr_d_q    <= '0;
      pc_d_q       <= '0;
      pc_plus4_d_q <= '0;
      valid_d_q    <= 1'b0;
      rd1_e_q      <= '0;
      rd2_e_q      <= '0;
      imm_ext_e_q  <= '0;
      pc_e_q       <= '0;
      pc_plus4_e_q <= '0;
      rs1_e_q      <= '0;
      rs2_e_q      <= '0;
      rd_e_q       <= '0;
      ctrl_e_q     <= '0;
      valid_e_q    <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      instr_d_q    <= instr_d_d;
      pc_d_q       <= pc_d_d;
      pc_plus4_d_q <= pc_plus4_d_d;
      valid_d_q    <= valid_d_d;
      rd1_e_q      <= rd1_e_d;
      rd2_e_q      <= rd2_e_d;
      imm_ext_e_q  <= imm_ext_e_d;
      pc_e_q       <= pc_e_d;
      pc_plus4_e_q <= pc_plus4_e_d;
      rs1_e_q      <= rs1_e_d;
      rs2_e_q      <= rs2_e_d;
      rd_e_q       <= rd_e_d;
      ctrl_e_q     <= ctrl_e_d;
      valid_e_q    <= valid_e_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign PCF         = pc_q;
  assign instrD      = instr_d_q;
  assign PCD         = pc_d_q;
  assign PCPlus4D    = pc_plus4_d_q;
  assign validD      = valid_d_q;
  assign RD1E        = rd1_e_q;
  assign RD2E        = rd2_e_q;
  assign immExtE     = imm_ext_e_q;
  assign PCE         = pc_e_q;
  assign PCPlus4E    = pc_plus4_e_q;
  assign Rs1E        = rs1_e_q;
  assign Rs2E        = rs2_e_q;
  assign RdE         = rd_e_q;
  assign ctrlE       = ctrl_e_q;
  assign validE      = valid_e_q;
  assign stallCycles = stall_cnt_q;
  assign flushCycles = flush_cnt_q;

endmodule

// File: tb/tb_pipe_front_regs.sv
// tb_pipe_front_regs
//   Self-checking bench for pipe_front_regs. The design is built with 4-bit
//   counters so that saturation is reachable quickly. The bench has three parts:
//   - a hand-computed vector table for the directed pipeline scenarios
//   - a saturation sequence
//   - a randomized run compared against a behavioural model
module tb_pipe_front_regs;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam int CNT_MAX = 15;

  logic              clk = 1'b0;
  logic              rst, stallF, stallD, flushD, flushE;
  logic [XLEN-1:0]   PCNextF, instrF, PCPlus4F, RD1D, RD2D, immExtD;
  logic [4:0]        Rs1D, Rs2D, RdD;
  logic [CTRL_W-1:0] ctrlD;
  logic [XLEN-1:0]   PCF, instrD, PCD, PCPlus4D;
  logic              validD, validE;
  logic [XLEN-1:0]   RD1E, RD2E, immExtE, PCE, PCPlus4E;
  logic [4:0]        Rs1E, Rs2E, RdE;
  logic [CTRL_W-1:0] ctrlE;
  logic [CNT_W-1:0]  stallCycles, flushCycles;

  int vecCount = 0;
  int errCount = 0;

  pipe_front_regs #(
    .XLEN(XLEN), .CTRL_W(CTRL_W), .RESET_PC(RESET_PC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD),
    .flushD(flushD), .flushE(flushE), .PCNextF(PCNextF), .instrF(instrF),
    .PCPlus4F(PCPlus4F), .RD1D(RD1D), .RD2D(RD2D), .immExtD(immExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ctrlD(ctrlD), .PCF(PCF),
    .instrD(instrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .validD(validD),
    .RD1E(RD1E), .RD2E(RD2E), .immExtE(immExtE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ctrlE(ctrlE), .validE(validE), .stallCycles(stallCycles),
    .flushCycles(flushCycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stallF, stallD, flushD, flushE;
    logic [31:0] pcNext, instr;
    logic [4:0]  rd;
    logic [31:0] expPCF, expInstrD;
    logic        expValidD, expValidE;
    logic [4:0]  expRdE;
    int          expStall, expFlush;
  } vec_t;

  // The behavioural model holds what each pipeline slot should contain.
  logic [31:0] mPc, mInstrD, mPcD, mPcp4D, mRd1E, mRd2E, mImmE, mPcE, mPcp4E;
  logic [4:0]  mRs1E, mRs2E, mRdE;
  logic [15:0] mCtrlE;
  logic        mValidD, mValidE;
  int          mStall, mFlush;

  // This task drives one cycle of stimulus, advances the model, and returns
  // #1 after the clock edge so the outputs are stable when they are checked.
  task automatic applyStimulus(input logic r, input logic sF, input logic sD,
                               input logic fD, input logic fE,
                               input logic [31:0] pcNext, input logic [31:0] ins,
                               input logic [31:0] p4, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] imm,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] rd, input logic [15:0] ctl);
    logic        oldValidD;
    logic [31:0] oldPc, oldPcD, oldPcp4D;
    rst = r; stallF = sF; stallD = sD; flushD = fD; flushE = fE;
    PCNextF = pcNext; instrF = ins; PCPlus4F = p4; RD1D = a; RD2D = b;
    immExtD = imm; Rs1D = r1; Rs2D = r2; RdD = rd; ctrlD = ctl;
    oldValidD = mValidD; oldPc = mPc; oldPcD = mPcD; oldPcp4D = mPcp4D;
    if (r) begin
      mPc = RESET_PC; mInstrD = 0; mPcD = 0; mPcp4D = 0; mValidD = 0;
      mRd1E = 0; mRd2E = 0; mImmE = 0; mPcE = 0; mPcp4E = 0;
      mRs1E = 0; mRs2E = 0; mRdE = 0; mCtrlE = 0; mValidE = 0;
      mStall = 0; mFlush = 0;
    end else begin
      if (!sF) mPc = pcNext;
      if (fE) begin
        mRd1E = 0; mRd2E = 0; mImmE = 0; mPcE = 0; mPcp4E = 0;
        mRs1E = 0; mRs2E = 0; mRdE = 0; mCtrlE = 0; mValidE = 0;
      end else begin
        mRd1E = a; mRd2E = b; mImmE = imm; mPcE = oldPcD; mPcp4E = oldPcp4D;
        mRs1E = r1; mRs2E = r2; mRdE = rd; mCtrlE = ctl; mValidE = oldValidD;
      end
      if (fD) begin
        mInstrD = 0; mPcD = 0; mPcp4D = 0; mValidD = 0;
      end else if (!sD) begin
        mInstrD = ins; mPcD = oldPc; mPcp4D = p4; mValidD = 1;
      end
      if (sD && !fD && mStall < CNT_MAX) mStall = mStall + 1;
      if ((fE || (fD && oldValidD)) && mFlush < CNT_MAX) mFlush = mFlush + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkAgainstModel();
    checkOutput("PCF", PCF, mPc);
    checkOutput("instrD", instrD, mInstrD);
    checkOutput("PCD", PCD, mPcD);
    checkOutput("PCPlus4D", PCPlus4D, mPcp4D);
    checkOutput("validD", 32'(validD), 32'(mValidD));
    checkOutput("RD1E", RD1E, mRd1E);
    checkOutput("RD2E", RD2E, mRd2E);
    checkOutput("immExtE", immExtE, mImmE);
    checkOutput("PCE", PCE, mPcE);
    checkOutput("PCPlus4E", PCPlus4E, mPcp4E);
    checkOutput("Rs1E", 32'(Rs1E), 32'(mRs1E));
    checkOutput("Rs2E", 32'(Rs2E), 32'(mRs2E));
    checkOutput("RdE", 32'(RdE), 32'(mRdE));
    checkOutput("ctrlE", 32'(ctrlE), 32'(mCtrlE));
    checkOutput("validE", 32'(validE), 32'(mValidE));
    checkOutput("stallCycles", 32'(stallCycles), 32'(mStall));
    checkOutput("flushCycles", 32'(flushCycles), 32'(mFlush));
  endtask

  // Directed vectors and their hand-computed expected values. The register
  // index RdD is driven as index+1 on every row.
  vec_t vecs[13];

  initial begin
    // rst stF stD flD flE  pcNext  instr   rd  PCF   instrD vD vE RdE st fl
    vecs[0]  = '{1,0,0,0,0, 32'h100, 32'hAAAA, 1, 32'h0,  32'h0,  0,0, 0, 0,0};
    vecs[1]  = '{0,0,0,0,0, 32'h4,   32'h11,   2, 32'h4,  32'h11, 1,0, 2, 0,0};
    vecs[2]  = '{0,0,0,0,0, 32'h8,   32'h22,   3, 32'h8,  32'h22, 1,1, 3, 0,0};
    vecs[3]  = '{0,1,1,0,1, 32'hC,   32'h33,   4, 32'h8,  32'h22, 1,0, 0, 1,1}; // load-use
    vecs[4]  = '{0,0,0,0,0, 32'hC,   32'h33,   5, 32'hC,  32'h33, 1,1, 5, 1,1};
    vecs[5]  = '{0,0,0,1,1, 32'h40,  32'h44,   6, 32'h40, 32'h0,  0,0, 0, 1,2}; // branch
    vecs[6]  = '{0,0,1,1,0, 32'h44,  32'h55,   7, 32'h44, 32'h0,  0,0, 7, 1,2}; // stall+flush, D empty
    vecs[7]  = '{0,0,0,0,0, 32'h48,  32'h66,   8, 32'h48, 32'h66, 1,0, 8, 1,2};
    vecs[8]  = '{0,0,1,1,0, 32'h4C,  32'h70,   9, 32'h4C, 32'h0,  0,1, 9, 1,3}; // stall+flush, D valid
    vecs[9]  = '{0,1,0,0,0, 32'h50,  32'h77,  10, 32'h4C, 32'h77, 1,0,10, 1,3};
    vecs[10] = '{0,0,1,0,0, 32'h54,  32'h88,  11, 32'h54, 32'h77, 1,1,11, 2,3};
    vecs[11] = '{1,1,0,0,0, 32'h58,  32'h90,  12, 32'h0,  32'h0,  0,0, 0, 0,0}; // mid-stream rst
    vecs[12] = '{0,0,0,0,0, 32'h4,   32'h99,  13, 32'h4,  32'h99, 1,0,13, 0,0};

    rst = 1'b1; stallF = 0; stallD = 0; flushD = 0; flushE = 0;
    PCNextF = 0; instrF = 0; PCPlus4F = 0; RD1D = 0; RD2D = 0; immExtD = 0;
    Rs1D = 0; Rs2D = 0; RdD = 0; ctrlD = 0;
    mPc = 0; mInstrD = 0; mPcD = 0; mPcp4D = 0; mValidD = 0;
    mRd1E = 0; mRd2E = 0; mImmE = 0; mPcE = 0; mPcp4E = 0;
    mRs1E = 0; mRs2E = 0; mRdE = 0; mCtrlE = 0; mValidE = 0;
    mStall = 0; mFlush = 0;

    $display("[TB] directed vector table");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].stallF, vecs[i].stallD, vecs[i].flushD,
                    vecs[i].flushE, vecs[i].pcNext, vecs[i].instr,
                    vecs[i].pcNext + 32'h4, vecs[i].instr ^ 32'h5A5A_0000,
                    vecs[i].instr + 32'h100, 32'hFFFF_0000 | vecs[i].instr,
                    5'(i), 5'(i + 2), vecs[i].rd, 16'hF000 | 16'(i));
      checkOutput($sformatf("v%0d.PCF", i), PCF, vecs[i].expPCF);
      checkOutput($sformatf("v%0d.instrD", i), instrD, vecs[i].expInstrD);
      checkOutput($sformatf("v%0d.validD", i), 32'(validD), 32'(vecs[i].expValidD));
      checkOutput($sformatf("v%0d.validE", i), 32'(validE), 32'(vecs[i].expValidE));
      checkOutput($sformatf("v%0d.RdE", i), 32'(RdE), 32'(vecs[i].expRdE));
      checkOutput($sformatf("v%0d.stallCycles", i), 32'(stallCycles), 32'(vecs[i].expStall));
      checkOutput($sformatf("v%0d.flushCycles", i), 32'(flushCycles), 32'(vecs[i].expFlush));
      if (vecs[i].rst || vecs[i].flushE) begin
        checkOutput($sformatf("v%0d.ctrlE", i), 32'(ctrlE), 32'h0);
      end
    end

    // Holding stallD for 20 cycles must pin the 4-bit counter at 15.
    $display("[TB] stall counter saturation");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sat.reset", 32'(stallCycles), 32'h0);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(0, 0, 1, 0, 0, 32'(k * 4), 32'h1000 + 32'(k), 0, 0, 0, 0, 1, 2, 3, 16'h1);
      checkOutput($sformatf("sat.k%0d", k), 32'(stallCycles), (k < 15) ? 32'(k) : 32'd15);
    end

    // Randomized traffic compared against the model on every output.
    $display("[TB] randomized run");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0);
    checkAgainstModel();
    for (int c = 0; c < 400; c++) begin
      logic [31:0] pcn;
      pcn = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 4) == 0), pcn, $urandom, pcn + 32'h4,
                    $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
                    5'($urandom), 16'($urandom));
      checkAgainstModel();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
